// File: rtl/des_key_sched_ctrl_pkg.sv
// Shared constants for the sequential DES key scheduler: PC-1 / PC-2
// permutation tables, the per-round shift schedule, FSM state encoding
// and the 28-bit circular rotate helpers.
package des_key_sched_ctrl_pkg;

    localparam int NROUNDS = 16;
    localparam int HALF_W  = 28;
    localparam int KEY_W   = 64;
    localparam int CD_W    = 2 * HALF_W;
    localparam int SK_W    = 48;

    // PC-1: entry i is the DES key bit (1-based, bit 1 = MSB) feeding output bit i+1
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry i is the {C,D} bit (1-based, C bit 1 = MSB) feeding subkey bit i+1
    localparam int PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before producing K1..K16 (index 0 = round 1)
    localparam int SHIFT_TAB [NROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit i set when SHIFT_TAB[i] is a double rotate; keeps the datapath a 2:1 mux
    function automatic logic [NROUNDS-1:0] shift_two_mask();
        logic [NROUNDS-1:0] m;
        m = '0;
        for (int i = 0; i < NROUNDS; i++) begin
            m[i] = (SHIFT_TAB[i] == 2);
        end
        return m;
    endfunction

    localparam logic [NROUNDS-1:0] SHIFT_TWO = shift_two_mask();

    // MSB holds DES bit 1, so a DES left rotate moves bits toward the MSB
    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Key-source and round-engine handshake bundle for des_key_sched_ctrl.
// master: the key scheduler itself; slave: key source + round engine side.
interface des_key_sched_ctrl_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        busy;
    logic        key_err;

    modport master (
        input  key_valid, key, decrypt, sk_ready,
        output key_ready, sk_valid, sk_data, sk_round, sk_last, busy, key_err
    );

    modport slave (
        output key_valid, key, decrypt, sk_ready,
        input  key_ready, sk_valid, sk_data, sk_round, sk_last, busy, key_err
    );
endinterface

// File: rtl/des_key_sched_ctrl_pc2.sv
// des_pc2: purely combinational 56->48 PC-2 compression of the {C,D} register.
module des_pc2
    import des_key_sched_ctrl_pkg::*;
(
    input  logic [CD_W-1:0] cd_in,
    output logic [SK_W-1:0] sk_out
);
    genvar gi;
    generate
        for (gi = 0; gi < SK_W; gi++) begin : g_pc2
            assign sk_out[SK_W-1-gi] = cd_in[CD_W - PC2_TAB[gi]];
        end
    endgenerate
endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: sequential DES key scheduler. Applies PC-1 once at key
// acceptance, then rotates C/D one round per subkey handshake and streams the
// PC-2 subkeys K1..K16 (encrypt) or K16..K1 (decrypt).
// Optional build macro DES_KEY_PARITY_CHK_EN: reject keys with any even-parity
// byte and pulse key_err instead of starting a schedule.
module des_key_sched_ctrl
    import des_key_sched_ctrl_pkg::*;
#(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    des_key_sched_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic              dir_q, dir_d;
    logic [3:0]        round_q, round_d;
    logic              key_err_q, key_err_d;

    logic [CD_W-1:0]   pc1_out;
    logic [SK_W-1:0]   pc2_out;
    logic              key_bad;
    logic              sk_valid;
    logic              sh_two;

    genvar gi;

    // PC-1 is pure wiring; the 8 parity bits never reach it
    generate
        for (gi = 0; gi < CD_W; gi++) begin : g_pc1
            assign pc1_out[CD_W-1-gi] = bus.key[KEY_W - PC1_TAB[gi]];
        end
    endgenerate

`ifdef DES_KEY_PARITY_CHK_EN
    logic [7:0] byte_ok;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign byte_ok[gi] = ^bus.key[8*gi +: 8];
        end
    endgenerate
    assign key_bad = ~&byte_ok;
`else
    logic [7:0] unused_par_bits;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign unused_par_bits[gi] = bus.key[8*gi];
        end
    endgenerate
    assign key_bad = 1'b0;
`endif

    // Encrypt walks the table forward from round n+2; decrypt walks it backward
    assign sh_two = dir_q ? SHIFT_TWO[4'd15 - round_q] : SHIFT_TWO[round_q + 4'd1];

    // Next-state, key load and per-handshake C/D rotation
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        dir_d     = dir_q;
        round_d   = round_q;
        key_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    if (key_bad) begin
                        key_err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        dir_d   = bus.decrypt;
                        round_d = 4'd0;
                        if (bus.decrypt) begin
                            // C16/D16 equals C0/D0 after the full 28-bit shift budget
                            c_d = pc1_out[CD_W-1:HALF_W];
                            d_d = pc1_out[HALF_W-1:0];
                        end else begin
                            c_d = rotl(pc1_out[CD_W-1:HALF_W], 1'b0);
                            d_d = rotl(pc1_out[HALF_W-1:0], 1'b0);
                        end
                    end
                end
            end
            ST_RUN: begin
                if (bus.sk_ready) begin
                    if (round_q == 4'(NROUNDS - 1)) begin
                        state_d = ST_IDLE;
                        round_d = 4'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                        if (dir_q) begin
                            c_d = rotr(c_q, sh_two);
                            d_d = rotr(d_q, sh_two);
                        end else begin
                            c_d = rotl(c_q, sh_two);
                            d_d = rotl(d_q, sh_two);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            dir_q     <= 1'b0;
            round_q   <= 4'd0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            dir_q     <= dir_d;
            round_q   <= round_d;
            key_err_q <= key_err_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_in  ({c_q, d_q}),
        .sk_out (pc2_out)
    );

    assign sk_valid     = (state_q == ST_RUN);
    assign bus.sk_valid = sk_valid;
    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.sk_round = round_q;
    assign bus.sk_last  = sk_valid && (round_q == 4'(NROUNDS - 1));
    assign bus.key_err  = key_err_q;

    generate
        if (IDLE_ZERO) begin : g_idle_zero
            assign bus.sk_data = sk_valid ? pc2_out : '0;
        end else begin : g_idle_pass
            assign bus.sk_data = pc2_out;
        end
    endgenerate

endmodule
